// File: rtl/data_bus_initiator.sv
// -----------------------------------------------------------------------------
// data_bus_initiator
//
// Purpose:
//   Turns single load/store commands into one bus transaction on a
//   request/grant + rvalid data bus. It positions store data and byte
//   enables onto the word lanes. It also aligns and extends load data coming
//   back. Each command produces exactly one response pulse. Misaligned or
//   illegal-size commands return an error without touching the bus.
//
// Optional feature:
//   RSP_TIMEOUT_EN - when defined, a wait counter aborts a transaction with an
//   error after TIMEOUT_CYCLES cycles without a grant or a read response.
//   When it is undefined, the block waits indefinitely and no counter exists.
//
// Ports:
//   clk, rst_ni          clock (rising edge), asynchronous active-low reset
//   cmd_*                command channel (valid/ready handshake)
//   rsp_*                one-cycle response pulse with held data/error
//   data_req_o..data_wdata_intg_o  bus request side
//   data_gnt_i..data_err_i         bus grant/response side
// -----------------------------------------------------------------------------
module data_bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [1:0]  cmd_size_i,
  input  logic        cmd_signed_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  output logic [6:0]  data_wdata_intg_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic [6:0]  data_rdata_intg_i,
  input  logic        data_err_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t      state, next_state;

  logic        accept;
  logic        misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic        timeout;

  logic        we_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [29:0] word_addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] load_shifted;
  logic [31:0] load_ext;

  logic        rsp_capture;
  logic [31:0] rsp_rdata_next;
  logic        rsp_err_next;

  // Read integrity is not checked by this block.
  logic        unused_intg;
  assign unused_intg = ^data_rdata_intg_i;

  // Ready is gated by reset so it stays low while reset is asserted, even
  // though the state register already sits in IDLE.
  assign cmd_ready_o = rst_ni && (state == IDLE);
  assign accept      = cmd_valid_i && cmd_ready_o;

  // Alignment check and lane placement for the incoming command.
  always_comb begin
    misaligned = 1'b0;
    be_calc    = 4'b1111;
    case (cmd_size_i)
      2'd0: begin
        be_calc = 4'b0001 << cmd_addr_i[1:0];
      end
      2'd1: begin
        misaligned = cmd_addr_i[0];
        be_calc    = 4'b0011 << cmd_addr_i[1:0];
      end
      2'd2: begin
        misaligned = (cmd_addr_i[1:0] != 2'b00);
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

  assign wdata_calc = cmd_wdata_i << {cmd_addr_i[1:0], 3'b000};

  // Load data is shifted down to bit 0, then truncated and extended.
  assign load_shifted = data_rdata_i >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      2'd0:    load_ext = {{24{signed_q & load_shifted[7]}},  load_shifted[7:0]};
      2'd1:    load_ext = {{16{signed_q & load_shifted[15]}}, load_shifted[15:0]};
      default: load_ext = load_shifted;
    endcase
  end

`ifdef RSP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // The counter restarts on every state change. This covers entry into REQ
  // and WAIT_RSP. It counts only while waiting on the bus.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt <= '0;
    end else if (state != next_state) begin
      tmo_cnt <= '0;
    end else if (state == REQ || state == WAIT_RSP) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  assign timeout = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic, and the value the response registers take when a
  // response is produced. A stray rvalid outside WAIT_RSP is ignored.
  always_comb begin
    next_state     = state;
    rsp_capture    = 1'b0;
    rsp_rdata_next = '0;
    rsp_err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned) begin
            next_state   = RESP;
            rsp_capture  = 1'b1;
            rsp_err_next = 1'b1;
          end else begin
            next_state = REQ;
          end
        end
      end
      REQ: begin
        if (data_gnt_i) begin
          next_state = WAIT_RSP;
        end else if (timeout) begin
          next_state   = RESP;
          rsp_capture  = 1'b1;
          rsp_err_next = 1'b1;
        end
      end
      WAIT_RSP: begin
        if (data_rvalid_i) begin
          next_state     = RESP;
          rsp_capture    = 1'b1;
          rsp_rdata_next = we_q ? 32'h0 : load_ext;
          rsp_err_next   = data_err_i;
        end else if (timeout) begin
          next_state   = RESP;
          rsp_capture  = 1'b1;
          rsp_err_next = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // The command is latched once at acceptance. This keeps the bus fields
  // stable for however long the grant takes.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= 2'd0;
      off_q       <= 2'd0;
      word_addr_q <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else if (accept && !misaligned) begin
      we_q        <= cmd_we_i;
      signed_q    <= cmd_signed_i;
      size_q      <= cmd_size_i;
      off_q       <= cmd_addr_i[1:0];
      word_addr_q <= cmd_addr_i[31:2];
      wdata_q     <= wdata_calc;
      be_q        <= be_calc;
    end
  end

  // Response data and error hold until the next response is produced.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (rsp_capture) begin
      rdata_q <= rsp_rdata_next;
      err_q   <= rsp_err_next;
    end
  end

  // Bus fields are driven only while requesting, so the bus is quiet otherwise.
  assign data_req_o        = (state == REQ);
  assign data_we_o         = data_req_o & we_q;
  assign data_be_o         = data_req_o ? be_q : 4'b0000;
  assign data_addr_o       = data_req_o ? {word_addr_q, 2'b00} : 32'h0;
  assign data_wdata_o      = data_req_o ? wdata_q : 32'h0;
  assign data_wdata_intg_o = 7'h00;

  assign rsp_valid_o = (state == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_data_bus_initiator.sv
// -----------------------------------------------------------------------------
// tb_data_bus_initiator
//
// Directed bench for data_bus_initiator. Inputs change 1 ns after the rising
// edge. Outputs are sampled on the falling edge. Expected values are worked
// out by hand from the address offset, size and bus data of each step.
// -----------------------------------------------------------------------------
module tb_data_bus_initiator;

  logic        clk;
  logic        rst_ni;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [1:0]  cmd_size_i;
  logic        cmd_signed_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [6:0]  data_wdata_intg_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic [6:0]  data_rdata_intg_i;
  logic        data_err_i;

  int checks = 0;
  int errors = 0;

  data_bus_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk               (clk),
    .rst_ni            (rst_ni),
    .cmd_valid_i       (cmd_valid_i),
    .cmd_ready_o       (cmd_ready_o),
    .cmd_we_i          (cmd_we_i),
    .cmd_size_i        (cmd_size_i),
    .cmd_signed_i      (cmd_signed_i),
    .cmd_addr_i        (cmd_addr_i),
    .cmd_wdata_i       (cmd_wdata_i),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_rdata_o       (rsp_rdata_o),
    .rsp_err_o         (rsp_err_o),
    .data_req_o        (data_req_o),
    .data_we_o         (data_we_o),
    .data_be_o         (data_be_o),
    .data_addr_o       (data_addr_o),
    .data_wdata_o      (data_wdata_o),
    .data_wdata_intg_o (data_wdata_intg_o),
    .data_gnt_i        (data_gnt_i),
    .data_rvalid_i     (data_rvalid_i),
    .data_rdata_i      (data_rdata_i),
    .data_rdata_intg_i (data_rdata_intg_i),
    .data_err_i        (data_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one bus transaction from the acceptance cycle through the response.
  // A stray rvalid with corrupted data is driven during every REQ cycle,
  // including the one where the grant arrives. It must not be taken.
  task automatic applyStimulus(
    input string       tag,
    input logic        we,
    input logic [1:0]  size,
    input logic        sgn,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input int          gnt_wait,
    input logic [31:0] rdata,
    input logic        berr,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_addr,
    input logic [31:0] exp_wdata,
    input logic [31:0] exp_rdata,
    input logic        exp_err
  );
    cmd_valid_i  = 1'b1;
    cmd_we_i     = we;
    cmd_size_i   = size;
    cmd_signed_i = sgn;
    cmd_addr_i   = addr;
    cmd_wdata_i  = wdata;
    @(negedge clk);
    checkOutput({tag, ".ready"}, {31'b0, cmd_ready_o}, 32'd1);
    nextCycle();
    cmd_valid_i = 1'b0;
    for (int i = 0; i <= gnt_wait; i++) begin
      data_gnt_i    = (i == gnt_wait);
      data_rvalid_i = 1'b1;
      data_rdata_i  = ~rdata;
      data_err_i    = ~berr;
      @(negedge clk);
      checkOutput({tag, ".req"},   {31'b0, data_req_o}, 32'd1);
      checkOutput({tag, ".we"},    {31'b0, data_we_o},  {31'b0, we});
      checkOutput({tag, ".be"},    {28'b0, data_be_o},  {28'b0, exp_be});
      checkOutput({tag, ".addr"},  data_addr_o,         exp_addr);
      checkOutput({tag, ".wdata"}, data_wdata_o,        exp_wdata);
      checkOutput({tag, ".ready_busy"}, {31'b0, cmd_ready_o}, 32'd0);
      nextCycle();
    end
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i  = rdata;
    data_err_i    = berr;
    @(negedge clk);
    checkOutput({tag, ".req_drop"}, {31'b0, data_req_o},  32'd0);
    checkOutput({tag, ".no_rsp"},   {31'b0, rsp_valid_o}, 32'd0);
    nextCycle();
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
    data_rdata_i  = 32'h0;
    @(negedge clk);
    checkOutput({tag, ".rsp_valid"}, {31'b0, rsp_valid_o}, 32'd1);
    checkOutput({tag, ".rsp_rdata"}, rsp_rdata_o,          exp_rdata);
    checkOutput({tag, ".rsp_err"},   {31'b0, rsp_err_o},   {31'b0, exp_err});
    checkOutput({tag, ".req_quiet"}, {31'b0, data_req_o},  32'd0);
    nextCycle();
    data_rvalid_i = 1'b1;
    @(negedge clk);
    checkOutput({tag, ".pulse_end"}, {31'b0, rsp_valid_o}, 32'd0);
    checkOutput({tag, ".hold"},      rsp_rdata_o,          exp_rdata);
    checkOutput({tag, ".idle"},      {31'b0, cmd_ready_o}, 32'd1);
    nextCycle();
    data_rvalid_i = 1'b0;
  endtask

  // Commands rejected at acceptance: no bus request, error pulse next cycle.
  task automatic rejectStimulus(input string tag, input logic we,
                                input logic [1:0] size, input logic [31:0] addr);
    cmd_valid_i  = 1'b1;
    cmd_we_i     = we;
    cmd_size_i   = size;
    cmd_signed_i = 1'b0;
    cmd_addr_i   = addr;
    cmd_wdata_i  = 32'hFFFF_FFFF;
    @(negedge clk);
    checkOutput({tag, ".ready"}, {31'b0, cmd_ready_o}, 32'd1);
    nextCycle();
    cmd_valid_i = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".no_req"},    {31'b0, data_req_o},  32'd0);
    checkOutput({tag, ".rsp_valid"}, {31'b0, rsp_valid_o}, 32'd1);
    checkOutput({tag, ".rsp_err"},   {31'b0, rsp_err_o},   32'd1);
    checkOutput({tag, ".rsp_rdata"}, rsp_rdata_o,          32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput({tag, ".pulse_end"}, {31'b0, rsp_valid_o}, 32'd0);
    checkOutput({tag, ".no_req2"},   {31'b0, data_req_o},  32'd0);
    nextCycle();
  endtask

  initial begin
    rst_ni            = 1'b0;
    cmd_valid_i       = 1'b0;
    cmd_we_i          = 1'b0;
    cmd_size_i        = 2'd0;
    cmd_signed_i      = 1'b0;
    cmd_addr_i        = 32'h0;
    cmd_wdata_i       = 32'h0;
    data_gnt_i        = 1'b0;
    data_rvalid_i     = 1'b0;
    data_rdata_i      = 32'h0;
    data_rdata_intg_i = 7'h00;
    data_err_i        = 1'b0;

    // Reset state: outputs quiet and command channel closed while in reset.
    @(negedge clk);
    checkOutput("reset.ready", {31'b0, cmd_ready_o}, 32'd0);
    checkOutput("reset.req",   {31'b0, data_req_o},  32'd0);
    checkOutput("reset.rsp",   {31'b0, rsp_valid_o}, 32'd0);
    checkOutput("reset.be",    {28'b0, data_be_o},   32'd0);
    checkOutput("reset.rdata", rsp_rdata_o,          32'd0);
    checkOutput("reset.intg",  {25'b0, data_wdata_intg_o}, 32'd0);
    nextCycle();
    rst_ni = 1'b1;
    @(negedge clk);
    checkOutput("release.ready", {31'b0, cmd_ready_o}, 32'd1);
    nextCycle();

    // Store byte at 0x103: lane 3, grant in the first request cycle.
    applyStimulus("sb_103", 1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_00A5, 0,
                  32'h0, 1'b0, 4'b1000, 32'h0000_0100, 32'hA500_0000, 32'h0, 1'b0);
    // Load half signed and unsigned at 0x202 from 0x8001_1234.
    applyStimulus("lh_s", 1'b0, 2'd1, 1'b1, 32'h0000_0202, 32'h0, 0,
                  32'h8001_1234, 1'b0, 4'b1100, 32'h0000_0200, 32'h0, 32'hFFFF_8001, 1'b0);
    applyStimulus("lh_u", 1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'h0, 1,
                  32'h8001_1234, 1'b0, 4'b1100, 32'h0000_0200, 32'h0, 32'h0000_8001, 1'b0);
    // Load byte signed at 0x001: byte 1 of 0x0000_8000 is 0x80.
    applyStimulus("lb_s", 1'b0, 2'd0, 1'b1, 32'h0000_0001, 32'h0, 0,
                  32'h0000_8000, 1'b0, 4'b0010, 32'h0000_0000, 32'h0, 32'hFFFF_FF80, 1'b0);
    // Load byte unsigned at 0x003 from 0x9A00_0000.
    applyStimulus("lb_u", 1'b0, 2'd0, 1'b0, 32'h0000_0003, 32'h0, 2,
                  32'h9A00_0000, 1'b0, 4'b1000, 32'h0000_0000, 32'h0, 32'h0000_009A, 1'b0);

    // Misaligned word load and illegal size: error without bus activity.
    rejectStimulus("lw_301", 1'b0, 2'd2, 32'h0000_0301);
    rejectStimulus("size3",  1'b1, 2'd3, 32'h0000_0000);

    // Aligned word load after an error response clears the error flag.
    applyStimulus("lw_400", 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0, 2,
                  32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF, 1'b0);
    // Store half with grant delayed five cycles and a bus error on response.
    applyStimulus("sh_err", 1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'h0000_1234, 5,
                  32'h5555_5555, 1'b1, 4'b1100, 32'h0000_0000, 32'h1234_0000, 32'h0, 1'b1);
    // A good word store resets error and returns zero data.
    applyStimulus("sw_ok", 1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 1,
                  32'h1111_1111, 1'b0, 4'b1111, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 1'b0);
    // Leave nonzero load data in the response register for the reset check.
    applyStimulus("lw_keep", 1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, 0,
                  32'h1234_5678, 1'b0, 4'b1111, 32'h0000_0020, 32'h0, 32'h1234_5678, 1'b0);

    // Reset while in WAIT_RSP: outputs clear at once and no response appears.
    cmd_valid_i  = 1'b1;
    cmd_we_i     = 1'b0;
    cmd_size_i   = 2'd2;
    cmd_addr_i   = 32'h0000_0040;
    nextCycle();
    cmd_valid_i = 1'b0;
    data_gnt_i  = 1'b1;
    nextCycle();
    data_gnt_i = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid.waiting", {31'b0, data_req_o}, 32'd0);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_mid.rsp",   {31'b0, rsp_valid_o}, 32'd0);
    checkOutput("rst_mid.rdata", rsp_rdata_o,          32'd0);
    checkOutput("rst_mid.ready", {31'b0, cmd_ready_o}, 32'd0);
    checkOutput("rst_mid.req",   {31'b0, data_req_o},  32'd0);
    nextCycle();
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'hABCD_0123;
    rst_ni        = 1'b1;
    @(negedge clk);
    checkOutput("rst_rel.ready", {31'b0, cmd_ready_o}, 32'd1);
    checkOutput("rst_rel.rsp",   {31'b0, rsp_valid_o}, 32'd0);
    nextCycle();
    data_rvalid_i = 1'b0;
    @(negedge clk);
    checkOutput("rst_rel.rsp2",  {31'b0, rsp_valid_o}, 32'd0);
    checkOutput("rst_rel.rdata", rsp_rdata_o,          32'd0);
    nextCycle();

    // Grant never arrives.
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b0;
    cmd_size_i  = 2'd2;
    cmd_addr_i  = 32'h0000_0080;
    nextCycle();
    cmd_valid_i = 1'b0;
`ifdef RSP_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checkOutput("tmo.req", {31'b0, data_req_o}, 32'd1);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("tmo.drop",  {31'b0, data_req_o},  32'd0);
    checkOutput("tmo.rsp",   {31'b0, rsp_valid_o}, 32'd1);
    checkOutput("tmo.err",   {31'b0, rsp_err_o},   32'd1);
    nextCycle();
`else
    begin
      int req_cycles = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (data_req_o === 1'b1) req_cycles++;
        nextCycle();
      end
      checkOutput("hang.req_cycles", 32'(req_cycles), 32'd100);
      @(negedge clk);
      checkOutput("hang.still_req", {31'b0, data_req_o},  32'd1);
      checkOutput("hang.no_rsp",    {31'b0, rsp_valid_o}, 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_bus_initiator.md
DATA_BUS_INITIATOR -- requirements
Module: data_bus_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max cycles waiting for data_gnt_i or data_rvalid_i (used only with RSP_TIMEOUT_EN).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock; all logic on rising edge.
- rst_ni  in  1  asynchronous reset, active-low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_we_i  in  1  1=store, 0=load.
- cmd_size_i  in  2  0=byte, 1=half, 2=word; 3 is illegal.
- cmd_signed_i  in  1  sign-extend load data.
- cmd_addr_i  in  32  byte address.
- cmd_wdata_i  in  32  store data, LSB-aligned.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  32  aligned, extended load data.
- rsp_err_o  out  1  error flag, valid with rsp_valid_o.
- data_req_o  out  1  bus request.
- data_we_o  out  1  bus write enable.
- data_be_o  out  4  bus byte enables.
- data_addr_o  out  32  word-aligned bus address.
- data_wdata_o  out  32  lane-positioned store data.
- data_wdata_intg_o  out  7  write ECC; constant 0.
- data_gnt_i  in  1  request granted.
- data_rvalid_i  in  1  response valid.
- data_rdata_i  in  32  read word.
- data_rdata_intg_i  in  7  read ECC; ignored.
- data_err_i  in  1  bus error, sampled with data_rvalid_i.

Function
REQ-003 SHALL implement FSM IDLE, REQ, WAIT_RSP, RESP.
REQ-004 cmd_ready_o SHALL be 1 only in IDLE; no other command is accepted until the current one has responded.
REQ-005 On acceptance, SHALL register the command and go to REQ, or go to RESP with rsp_err_o=1 and no bus activity if misaligned (half with addr[0]=1, word with addr[1:0]!=0) or cmd_size_i=3.
REQ-006 In REQ, SHALL drive data_req_o=1 with stable we/be/addr/wdata until the cycle data_gnt_i=1, then go to WAIT_RSP with data_req_o=0 next cycle.
REQ-007 data_addr_o SHALL be {addr[31:2],2'b00}; data_be_o SHALL be 4'b0001<<off (byte), 4'b0011<<off (half), 4'b1111 (word), off=addr[1:0].
REQ-008 data_wdata_o SHALL be cmd_wdata_i<<(8*off); data_we_o SHALL follow cmd_we_i.
REQ-009 In WAIT_RSP, on data_rvalid_i=1 SHALL capture data and data_err_i, then go to RESP.
REQ-010 Load data SHALL be data_rdata_i>>(8*off), truncated to 8/16/32 bits, zero-extended, or sign-extended if cmd_signed_i=1; store responses SHALL return rsp_rdata_o=0.
REQ-011 RESP SHALL assert rsp_valid_o for exactly one cycle (no backpressure), then return to IDLE; minimum command-to-response latency with zero-wait responder SHALL be 3 cycles after acceptance.
REQ-012 data_rvalid_i in IDLE, REQ or RESP SHALL be ignored; data_rvalid_i coincident with data_gnt_i SHALL not be taken as the response.
REQ-013 rsp_rdata_o and rsp_err_o SHALL hold their values until the next response.

Reset
REQ-014 On rst_ni=0, SHALL immediately enter IDLE with data_req_o, data_we_o, rsp_valid_o, rsp_err_o=0, data_be_o=0, data_addr_o, data_wdata_o, rsp_rdata_o=0, cmd_ready_o=0 while in reset.
REQ-015 Reset mid-transaction SHALL abandon the transaction without a response; cmd_ready_o=1 the first cycle after release.

Configuration
REQ-016 With RSP_TIMEOUT_EN defined, a counter SHALL clear on entry to REQ and WAIT_RSP; reaching TIMEOUT_CYCLES without gnt or rvalid SHALL drop data_req_o, go to RESP with rsp_err_o=1; a later stray rvalid is ignored per REQ-012.
REQ-017 Without RSP_TIMEOUT_EN, SHALL wait indefinitely with no counter logic present; TIMEOUT_CYCLES unused.

Verification
REQ-018 Store byte addr=0x103, wdata=0xA5, gnt same cycle -> be=4'b1000, addr=0x100, wdata=0xA5000000, rsp_err_o=0 three cycles after acceptance.
REQ-019 Load half signed addr=0x202, rdata_i=0x8001_1234 -> rsp_rdata_o=0xFFFF8001; unsigned -> 0x00008001.
REQ-020 Load word addr=0x301 -> no data_req_o, rsp_valid_o next cycle with rsp_err_o=1.
REQ-021 gnt held low 5 cycles -> request signals stable all 5 cycles, one request only; data_err_i=1 with rvalid -> rsp_err_o=1.
REQ-022 RSP_TIMEOUT_EN, TIMEOUT_CYCLES=16, gnt never asserted -> data_req_o drops, rsp_err_o=1 after 16 cycles; without macro, still requesting at 100 cycles.
REQ-023 rst_ni low in WAIT_RSP -> outputs zero immediately, no rsp_valid_o, cmd_ready_o=1 first cycle after release.
